// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing constants, source FSM states and colour-bar table
package vga_pkg;

    localparam int HD_640 = 640;
    localparam int VD_480 = 480;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } src_state_t;

    // RGB444, left to right: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [11:0] BAR_LUT [8] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - synchronous FIFO, registered storage, head visible one clk after write
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   wr, din        write strobe and data
//   rd             pop strobe
//   dout           current head entry (meaningful only while !empty)
//   empty, full    occupancy flags
//   count          number of stored entries, 0..DEPTH
module stream_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [W-1:0]             din,
    input  logic                     rd,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));

    // A write into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_wr = wr && (!full || rd);
    assign do_rd = rd && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/frame_stream_src.sv
// rtl/frame_stream_src.sv - raster framebuffer reader feeding a valid/ready pixel stream
//
// Scans an HD x VD framebuffer in raster order through a 1-clk-latency read port and
// streams {rgb, start} pixels; start marks pixel (0,0). A credit-limited prefetch FIFO
// hides the read latency so the sink can take one pixel per clk.
// Optional build macro TEST_PATTERN_EN: pattern_sel selects 8 vertical colour bars
// instead of framebuffer data.
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   enable         stream frames; sampled only at frame boundaries
//   pattern_sel    colour-bar pattern select (TEST_PATTERN_EN builds only)
//   fb_rd_en       framebuffer read strobe
//   fb_rd_addr     linear read address y*HD+x
//   fb_rd_data     read data, valid 1 clk after fb_rd_en
//   so_data        [CD:1]=rgb, [0]=start
//   so_valid       stream valid
//   so_ready       stream ready
//   frame_done     1-clk pulse the cycle after the last pixel of a frame is popped
module frame_stream_src
    import vga_pkg::*;
#(
    parameter int CD         = 12,
    parameter int HD         = HD_640,
    parameter int VD         = VD_480,
    parameter int AW         = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          pattern_sel,
    output logic          fb_rd_en,
    output logic [AW-1:0] fb_rd_addr,
    input  logic [CD-1:0] fb_rd_data,
    output logic [CD:0]   so_data,
    output logic          so_valid,
    input  logic          so_ready,
    output logic          frame_done
);

    localparam int XW = $clog2(HD);
    localparam int YW = $clog2(VD);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    // FIFO entry: {last, rgb, start}; last drives frame_done on pop
    localparam int FW = CD + 2;

    src_state_t    state;
    src_state_t    state_next;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [AW-1:0] addr;
    logic          inflight;
    logic          tag_d;
    logic          last_d;
    logic          issue;
    logic          x_last;
    logic          y_last;
    logic          frame_last;
    logic [CW:0]   credit;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          unused_fifo_full;
    logic [FW-1:0] fifo_din;
    logic [FW-1:0] fifo_dout;
    logic [CD-1:0] wr_rgb;
    logic          pop;

    assign x_last     = (x == XW'(HD - 1));
    assign y_last     = (y == YW'(VD - 1));
    assign frame_last = x_last && y_last;

    // Entries already stored plus the read still in the pipe must leave room for this one,
    // so a write can never land on a full FIFO.
    assign credit = {1'b0, fifo_count} + (CW+1)'(inflight);
    assign issue  = (state == RUN) && (credit < (CW+1)'(FIFO_DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // enable is only consulted as the last pixel of a frame is issued
                if (issue && frame_last && !enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (state == IDLE) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (issue) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
            addr <= frame_last ? '0 : addr + 1'b1;
        end
    end

    // Side information travels one clk alongside the read so it meets fb_rd_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            tag_d    <= 1'b0;
            last_d   <= 1'b0;
        end else begin
            inflight <= issue;
            tag_d    <= issue && (x == '0) && (y == '0);
            last_d   <= issue && frame_last;
        end
    end

`ifdef TEST_PATTERN_EN
    localparam int BW = (HD / 8 > 1) ? $clog2(HD / 8) : 1;

    logic          pat_mode;
    logic [2:0]    bar;
    logic [BW-1:0] bar_x;
    logic [CD-1:0] pat_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_mode <= 1'b0;
            bar      <= '0;
            bar_x    <= '0;
            pat_d    <= '0;
        end else begin
            if (state == IDLE && enable) begin
                pat_mode <= pattern_sel;
            end
            if (issue) begin
                pat_d <= CD'(BAR_LUT[bar]);
                // bar_x counts pixels within a bar; restarting at line end keeps bars aligned
                if (x_last) begin
                    bar_x <= '0;
                    bar   <= '0;
                end else if (bar_x == BW'(HD / 8 - 1)) begin
                    bar_x <= '0;
                    bar   <= bar + 3'd1;
                end else begin
                    bar_x <= bar_x + 1'b1;
                end
            end
        end
    end

    assign fb_rd_en = issue && !pat_mode;
    assign wr_rgb   = pat_mode ? pat_d : fb_rd_data;
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;

    assign fb_rd_en = issue;
    assign wr_rgb   = fb_rd_data;
`endif

    assign fb_rd_addr = addr;
    assign fifo_din   = {last_d, wr_rgb, tag_d};

    stream_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (inflight),
        .din   (fifo_din),
        .rd    (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (unused_fifo_full),
        .count (fifo_count)
    );

    assign so_valid = !fifo_empty;
    assign pop      = so_valid && so_ready;
    // Storage is not reset, so the head is masked while nothing is valid.
    assign so_data  = fifo_empty ? '0 : fifo_dout[CD:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop && fifo_dout[FW-1];
        end
    end

endmodule
